// File: rtl/seg7_scan_reader_if.sv
// Frame delivery bus for seg7_scan_reader: decoded digits plus a valid/ready handshake.
// The master (the reader) drives the frame; the slave (the consumer) drives READY.
interface seg7_scan_reader_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] VALUE;
  logic [NDIG-1:0]   DOTS;
  logic [NDIG-1:0]   ERR;
  logic              VALID;
  logic              READY;
  logic              OVR;

  modport master (
    output VALUE,
    output DOTS,
    output ERR,
    output VALID,
    output OVR,
    input  READY
  );

  modport slave (
    input  VALUE,
    input  DOTS,
    input  ERR,
    input  VALID,
    input  OVR,
    output READY
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed active-low 7-segment bus, decodes each digit, and delivers whole frames.
// Optional macro SEG7_SCAN_TIMEOUT_EN discards partial frames after TIMEOUT idle cycles.
//
// state | meaning
// SCAN  | collecting digits, VALID low
// HOLD  | frame presented, VALID high, outputs frozen until READY
module seg7_scan_reader #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [7:0]           nSEG,
  input  logic [NDIG-1:0]      nDIG,
  seg7_scan_reader_if.master   frame
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] STABLE_V = CW'(STABLE_CYC);

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_n;

  logic [7:0]      seg_s1, seg_s2, seg_p;
  logic [NDIG-1:0] dig_s1, dig_s2, dig_p;
  logic [CW-1:0]   cnt, cnt_n;
  logic            done, done_n;
  logic            legal, same, fire;
  logic [NDIG-1:0] low, fire_mask;
  logic [4:0]      dec;

  logic [NDIG-1:0]       got, got_n;
  logic [NDIG-1:0][3:0]  slot_val;
  logic [NDIG-1:0]       slot_dot, slot_err;
  logic [4*NDIG-1:0]     value_q;
  logic [NDIG-1:0]       dots_q, err_q;
  logic                  ovr_q;
  logic                  complete, load, ovr_set, tmo_hit;

  // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h58:   r = 5'h07;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
      dig_s1 <= '1;
      dig_s2 <= '1;
      dig_p  <= '1;
    end else begin
      seg_s1 <= nSEG;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      dig_s1 <= nDIG;
      dig_s2 <= dig_s1;
      dig_p  <= dig_s2;
    end
  end

  // Stability tracking: done blocks a second capture of an unchanged pattern.
  always_comb begin
    low   = ~dig_s2;
    legal = (low != '0) && ((low & (low - NDIG'(1))) == '0);
    same  = (seg_s2 == seg_p) && (dig_s2 == dig_p);
    cnt_n = cnt;
    if (!legal) begin
      cnt_n = '0;
    end else if (!same) begin
      cnt_n = CW'(1);
    end else if (cnt != STABLE_V) begin
      cnt_n = cnt + CW'(1);
    end
    fire      = legal && (cnt_n == STABLE_V) && !(same && done);
    done_n    = fire || (legal && same && done);
    fire_mask = fire ? low : '0;
    dec       = decode(seg_s2[6:0]);
  end

`ifdef SEG7_SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (got != '0) && !fire && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_cnt <= '0;
    end else if (fire || (got == '0) || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    ovr_set  = 1'b0;
    complete = &got;
    case (state)
      SCAN: begin
        if (complete) begin
          load    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (complete) begin
          if (frame.READY) begin
            load = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (frame.READY) begin
          state_n = SCAN;
        end
      end
      default: state_n = SCAN;
    endcase
    // A capture landing in the completion cycle starts the next frame.
    if (complete || tmo_hit) begin
      got_n = fire_mask;
    end else begin
      got_n = got | fire_mask;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= '0;
      done     <= 1'b0;
      got      <= '0;
      slot_val <= '0;
      slot_dot <= '0;
      slot_err <= '0;
      value_q  <= '0;
      dots_q   <= '0;
      err_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      done <= done_n;
      got  <= got_n;
      for (int i = 0; i < NDIG; i++) begin
        if (fire_mask[i]) begin
          slot_val[i] <= dec[3:0];
          slot_err[i] <= dec[4];
          slot_dot[i] <= ~seg_s2[7];
        end
      end
      if (load) begin
        for (int i = 0; i < NDIG; i++) begin
          value_q[4*i +: 4] <= slot_val[i];
        end
        dots_q <= slot_dot;
        err_q  <= slot_err;
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign frame.VALUE = value_q;
  assign frame.DOTS  = dots_q;
  assign frame.ERR   = err_q;
  assign frame.VALID = (state == HOLD);
  assign frame.OVR   = ovr_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scenarios plus a randomized
// digit stream checked against an array-based frame assembly model.
module tb_seg7_scan_reader;
  localparam int NDIG = 4;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  err;
  } frame_t;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [7:0]      nSEG;
  logic [NDIG-1:0] nDIG;

  int vectors     = 0;
  int miscompares = 0;

  frame_t rxq[$];
  frame_t expq[$];

  logic [6:0] enc [16];
  logic [6:0] bad [4];

  seg7_scan_reader_if #(.NDIG(NDIG)) ifc ();

  seg7_scan_reader #(
    .NDIG(NDIG),
    .STABLE_CYC(4),
    .TIMEOUT(65535)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .nSEG (nSEG),
    .nDIG (nDIG),
    .frame(ifc)
  );

  always #5 CLK = ~CLK;

  // Every cycle with VALID and READY high transfers one frame.
  always @(negedge CLK) begin
    if (nRST && ifc.VALID && ifc.READY) begin
      rxq.push_back({ifc.VALUE, ifc.DOTS, ifc.ERR});
    end
  end

  // Inputs are changed just after the rising edge; callers stay aligned to that point.
  task automatic drive(input int d, input logic [7:0] seg, input int cyc);
    nDIG = ~(NDIG'(1) << d);
    nSEG = seg;
    repeat (cyc) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle(input int cyc);
    nDIG = '1;
    nSEG = '1;
    repeat (cyc) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_rx(input int budget, output bit ok, output frame_t f);
    ok = 1'b0;
    f  = '0;
    for (int i = 0; i < budget; i++) begin
      if (rxq.size() > 0) begin
        f  = rxq.pop_front();
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    nRST      = 1'b0;
    nSEG      = '1;
    nDIG      = '1;
    ifc.READY = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (ifc.VALUE !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_value got %h want 0000", ifc.VALUE);
    end
    vectors++;
    if (ifc.DOTS !== 4'h0 || ifc.ERR !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_dots_err got %b/%b want 0000/0000", ifc.DOTS, ifc.ERR);
    end
    vectors++;
    if (ifc.VALID !== 1'b0 || ifc.OVR !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_ovr got %b/%b want 0/0", ifc.VALID, ifc.OVR);
    end
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    bit     ok;
    frame_t f;
    ifc.READY = 1'b1;
    drive(0, 8'hF9, 8);
    drive(1, 8'hA4, 8);
    drive(2, 8'hB0, 8);
    drive(3, 8'h99, 8);
    idle(2);
    wait_rx(40, ok, f);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_timeout got no frame want 4321");
    end else begin
      vectors++;
      if (f.value !== 16'h4321 || f.dots !== 4'h0 || f.err !== 4'h0) begin
        miscompares++;
        $display("FAIL basic_frame got %h/%b/%b want 4321/0000/0000", f.value, f.dots, f.err);
      end
    end
    idle(12);
    vectors++;
    if (rxq.size() != 0 || ifc.VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_single_pulse got %0d extra frames valid=%b want 0 and 0", rxq.size(), ifc.VALID);
      rxq.delete();
    end
  endtask

  task automatic test_dot_err();
    bit     ok;
    frame_t f;
    drive(0, 8'hC0, 6);
    drive(1, 8'hFF, 6);
    drive(2, 8'h02, 6);
    drive(3, 8'hF9, 6);
    idle(2);
    wait_rx(40, ok, f);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL dot_err_timeout got no frame want 1600");
    end else begin
      vectors++;
      if (f.value !== 16'h1600) begin
        miscompares++;
        $display("FAIL dot_err_value got %h want 1600", f.value);
      end
      vectors++;
      if (f.dots !== 4'b0100 || f.err !== 4'b0010) begin
        miscompares++;
        $display("FAIL dot_err_flags got %b/%b want 0100/0010", f.dots, f.err);
      end
    end
    idle(4);
  endtask

  task automatic test_no_capture();
    bit     ok;
    frame_t f;
    drive(0, 8'hF9, 3);
    idle(6);
    nDIG = 4'b1100;
    nSEG = 8'hA4;
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    idle(6);
    drive(1, 8'hA4, 6);
    drive(2, 8'hB0, 6);
    drive(3, 8'h99, 6);
    idle(20);
    vectors++;
    if (rxq.size() != 0 || ifc.VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL no_capture got %0d frames valid=%b want 0 and 0", rxq.size(), ifc.VALID);
      rxq.delete();
    end
    drive(0, 8'hC0, 6);
    idle(2);
    wait_rx(40, ok, f);
    vectors++;
    if (!ok || f.value !== 16'h4320) begin
      miscompares++;
      $display("FAIL no_capture_complete got ok=%b value=%h want 1 and 4320", ok, f.value);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    bit seen;
    ifc.READY = 1'b0;
    drive(0, 8'h99, 6);
    drive(1, 8'hB0, 6);
    drive(2, 8'hA4, 6);
    drive(3, 8'hF9, 6);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ifc.VALID === 1'b1) seen = 1'b1;
      else idle(1);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL ovr_first_valid got 0 want 1");
    end
    drive(0, 8'h80, 6);
    drive(1, 8'hF8, 6);
    drive(2, 8'h82, 6);
    drive(3, 8'h92, 6);
    idle(12);
    vectors++;
    if (ifc.VALID !== 1'b1 || ifc.VALUE !== 16'h1234) begin
      miscompares++;
      $display("FAIL ovr_hold got valid=%b value=%h want 1 and 1234", ifc.VALID, ifc.VALUE);
    end
    vectors++;
    if (ifc.OVR !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_flag got %b want 1", ifc.OVR);
    end
    ifc.READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (ifc.VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_release got valid=%b want 0", ifc.VALID);
    end
    vectors++;
    if (rxq.size() != 1 || rxq[0].value !== 16'h1234) begin
      miscompares++;
      $display("FAIL ovr_transfer got %0d frames want 1 frame of 1234", rxq.size());
    end
    rxq.delete();
    @(posedge CLK);
    #1;
    idle(4);
  endtask

  task automatic test_reset_midframe();
    bit     ok;
    frame_t f;
    drive(0, 8'h80, 6);
    drive(1, 8'hF8, 6);
    nRST = 1'b0;
    idle(3);
    nRST = 1'b1;
    idle(3);
    vectors++;
    if (ifc.OVR !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ovr got %b want 0", ifc.OVR);
    end
    drive(2, 8'h80, 6);
    drive(3, 8'h90, 6);
    idle(20);
    vectors++;
    if (rxq.size() != 0) begin
      miscompares++;
      $display("FAIL rst_stale got %0d frames want 0", rxq.size());
      rxq.delete();
    end
    drive(1, 8'hF8, 6);
    drive(0, 8'h82, 6);
    idle(2);
    wait_rx(40, ok, f);
    vectors++;
    if (!ok || f.value !== 16'h9876 || ifc.OVR !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_frame got ok=%b value=%h ovr=%b want 1, 9876, 0", ok, f.value, ifc.OVR);
    end
    idle(4);
  endtask

  task automatic test_random();
    logic [3:0] m_val [NDIG];
    logic       m_dot [NDIG];
    logic       m_err [NDIG];
    logic       m_got [NDIG];
    bit         all;
    bit         ok;
    frame_t     f, e;
    int         d, hold, nib;
    logic       dot, is_bad;
    logic [6:0] pat;
    for (int i = 0; i < NDIG; i++) m_got[i] = 1'b0;
    expq.delete();
    for (int step = 0; step < 120; step++) begin
      d      = int'($urandom_range(0, NDIG - 1));
      hold   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 9));
      nib    = int'($urandom_range(0, 15));
      dot    = 1'($urandom_range(0, 1));
      is_bad = ($urandom_range(0, 7) == 0);
      pat    = is_bad ? bad[$urandom_range(0, 3)] : enc[nib];
      if (!is_bad && nib == 7 && $urandom_range(0, 1) == 1) pat = 7'h78;
      if (hold >= 4) begin
        m_val[d] = is_bad ? 4'h0 : 4'(nib);
        m_err[d] = is_bad;
        m_dot[d] = dot;
        m_got[d] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < NDIG; i++) all = all && m_got[i];
        if (all) begin
          for (int i = 0; i < NDIG; i++) begin
            e.value[4*i +: 4] = m_val[i];
            e.dots[i]         = m_dot[i];
            e.err[i]          = m_err[i];
            m_got[i]          = 1'b0;
          end
          expq.push_back(e);
        end
      end
      drive(d, {~dot, pat}, hold);
      idle(1);
    end
    idle(20);
    foreach (expq[k]) begin
      wait_rx(2, ok, f);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rand_missing frame %0d got none want %h/%b/%b", k, expq[k].value, expq[k].dots, expq[k].err);
      end else if (f !== expq[k]) begin
        miscompares++;
        $display("FAIL rand_frame %0d got %h/%b/%b want %h/%b/%b", k, f.value, f.dots, f.err,
                 expq[k].value, expq[k].dots, expq[k].err);
      end
    end
    vectors++;
    if (rxq.size() != 0 || ifc.OVR !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_extra got %0d extra frames ovr=%b want 0 and 0", rxq.size(), ifc.OVR);
    end
  endtask

  initial begin
    enc = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bad = '{7'h7F, 7'h7E, 7'h01, 7'h7D};
    test_reset();
    test_basic();
    test_dot_err();
    test_no_capture();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
